// File: rtl/sdh_pkg.sv
// Shared types, frame geometry constants and slot decode for the STM-N frame sequencer.
package sdh_pkg;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_STM,
    REG_AU4,
    REG_VC4,
    REG_TUG3
  } region_e;

  typedef enum logic [1:0] {
    HUNT,
    PRESYNC,
    SYNC
  } fsm_state_e;

  localparam int unsigned SDH_ROWS = 9;
  localparam int unsigned SDH_COLS = 90;
  localparam int unsigned H3_ROW   = 3;
  localparam int unsigned POH_COL  = 3;

  // Section overhead in cols 0..2 (AU4 pointer row 3), POH column 3 on STS 0 only.
  function automatic region_e sdh_region(input int unsigned row,
                                         input int unsigned col,
                                         input int unsigned sts);
    region_e reg_v;
    if (col < POH_COL) begin
      reg_v = (row == H3_ROW) ? REG_AU4 : REG_STM;
    end else if (col == POH_COL) begin
      reg_v = (sts == 0) ? REG_VC4 : REG_NONE;
    end else begin
      reg_v = REG_TUG3;
    end
    return reg_v;
  endfunction

endpackage

// File: rtl/sdh_pos_cnt.sv
// Row/column/STS position counter for one direction of an STM-N frame.
// i_load forces the current position to (0,0,0) so the marked byte is position zero.
module sdh_pos_cnt
  import sdh_pkg::*;
#(
  parameter int NSTS = 3,
  parameter int RWID = 4,
  parameter int CWID = 7,
  parameter int SWID = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  output logic [RWID-1:0] o_row,
  output logic [CWID-1:0] o_col,
  output logic [SWID-1:0] o_sts,
  output logic            o_wrap
);

  logic [RWID-1:0] r_row;
  logic [CWID-1:0] r_col;
  logic [SWID-1:0] r_sts;
  logic [RWID-1:0] w_row, w_row_next;
  logic [CWID-1:0] w_col, w_col_next;
  logic [SWID-1:0] w_sts, w_sts_next;

  always_comb begin
    w_row      = i_load ? '0 : r_row;
    w_col      = i_load ? '0 : r_col;
    w_sts      = i_load ? '0 : r_sts;
    w_row_next = w_row;
    w_col_next = w_col;
    w_sts_next = w_sts + SWID'(1);
    if (w_sts == SWID'(NSTS - 1)) begin
      w_sts_next = '0;
      w_col_next = w_col + CWID'(1);
      if (w_col == CWID'(SDH_COLS - 1)) begin
        w_col_next = '0;
        w_row_next = (w_row == RWID'(SDH_ROWS - 1)) ? '0 : w_row + RWID'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
      r_sts <= '0;
    end else begin
      r_row <= w_row_next;
      r_col <= w_col_next;
      r_sts <= w_sts_next;
    end
  end

  assign o_row  = w_row;
  assign o_col  = w_col;
  assign o_sts  = w_sts;
  // Natural arrival at (0,0,0), independent of any load.
  assign o_wrap = (r_row == '0) && (r_col == '0) && (r_sts == '0);

endmodule

// File: rtl/sdh_frame_seq.sv
// STM-N Tx/Rx frame sequencer: position counting, slot enables, Tx byte mux,
// Rx byte fan-out with frame alignment, pointer justification and LOF reporting.
module sdh_frame_seq
  import sdh_pkg::*;
#(
  parameter int WID     = 8,
  parameter int NSTS    = 3,
  parameter int RWID    = 4,
  parameter int CWID    = 7,
  parameter int SWID    = 4,
  parameter int CONFIRM = 2,
  parameter int LOSSCNT = 4
) (
  input  logic            clk19,
  input  logic            rst,
  input  logic            rxsof,
  input  logic [WID-1:0]  dirx,
  input  logic            inc,
  input  logic            dec,
  output logic            stmentx,
  output logic            au4entx,
  output logic            vc4entx,
  output logic            tug3entx,
  input  logic [WID-1:0]  stmdi,
  input  logic [WID-1:0]  au4di,
  input  logic [WID-1:0]  vc4di,
  input  logic [WID-1:0]  tug3di,
  output logic [WID-1:0]  dotx,
  output logic            txsof,
  output logic [RWID-1:0] row,
  output logic [CWID-1:0] col,
  output logic [SWID-1:0] sts,
  output logic            stmenrx,
  output logic            au4enrx,
  output logic            vc4enrx,
  output logic            tug3enrx,
  output logic [WID-1:0]  rxdo,
  output logic            rxlocked,
  output logic            lof
);

  localparam int GWID = (CONFIRM > 1) ? $clog2(CONFIRM) : 1;
  localparam int BWID = (LOSSCNT > 1) ? $clog2(LOSSCNT) : 1;

  logic [RWID-1:0] w_tx_row;
  logic [CWID-1:0] w_tx_col;
  logic [SWID-1:0] w_tx_sts;
  logic            w_tx_wrap;
  region_e         w_tx_reg;
  logic [WID-1:0]  r_dotx;
  logic            r_txsof;

  sdh_pos_cnt #(.NSTS(NSTS), .RWID(RWID), .CWID(CWID), .SWID(SWID)) u_tx_cnt (
    .clk    (clk19),
    .rst_n  (rst),
    .i_load (1'b0),
    .o_row  (w_tx_row),
    .o_col  (w_tx_col),
    .o_sts  (w_tx_sts),
    .o_wrap (w_tx_wrap)
  );

  assign w_tx_reg = sdh_region(32'(w_tx_row), 32'(w_tx_col), 32'(w_tx_sts));
  assign stmentx  = (w_tx_reg == REG_STM);
  assign au4entx  = (w_tx_reg == REG_AU4);
  assign vc4entx  = (w_tx_reg == REG_VC4);
  assign tug3entx = (w_tx_reg == REG_TUG3);
  assign row      = w_tx_row;
  assign col      = w_tx_col;
  assign sts      = w_tx_sts;

  always_ff @(posedge clk19 or negedge rst) begin
    if (!rst) begin
      r_dotx  <= '0;
      r_txsof <= 1'b0;
    end else begin
      r_txsof <= w_tx_wrap;
      case (w_tx_reg)
        REG_STM:  r_dotx <= stmdi;
        REG_AU4:  r_dotx <= au4di;
        REG_VC4:  r_dotx <= vc4di;
        REG_TUG3: r_dotx <= tug3di;
        default:  r_dotx <= '0;
      endcase
    end
  end

  assign dotx  = r_dotx;
  assign txsof = r_txsof;

  fsm_state_e      r_state;
  logic [GWID-1:0] r_good;
  logic [BWID-1:0] r_bad;
  logic            r_bad_seen;
  logic            r_lof;
  logic            w_rx_load, w_rx_wrap, w_rx_first, w_rx_sync;
  logic [RWID-1:0] w_rx_row;
  logic [CWID-1:0] w_rx_col;
  logic [SWID-1:0] w_rx_sts;
  region_e         w_rx_reg;
  logic            r_inc_pend, r_dec_pend, r_inc_act, r_dec_act;
  logic            r_stmenrx, r_au4enrx, r_vc4enrx, r_tug3enrx;
  logic [WID-1:0]  r_rxdo;

  assign w_rx_load  = (r_state == HUNT) && rxsof;
  assign w_rx_first = w_rx_wrap || w_rx_load;
  assign w_rx_sync  = (r_state == SYNC);

  sdh_pos_cnt #(.NSTS(NSTS), .RWID(RWID), .CWID(CWID), .SWID(SWID)) u_rx_cnt (
    .clk    (clk19),
    .rst_n  (rst),
    .i_load (w_rx_load),
    .o_row  (w_rx_row),
    .o_col  (w_rx_col),
    .o_sts  (w_rx_sts),
    .o_wrap (w_rx_wrap)
  );

  // Requests collect during one frame and become active for the whole next frame,
  // so anything arriving during the applying row 3 waits one more frame.
  always_ff @(posedge clk19 or negedge rst) begin
    if (!rst) begin
      r_inc_pend <= 1'b0;
      r_dec_pend <= 1'b0;
      r_inc_act  <= 1'b0;
      r_dec_act  <= 1'b0;
    end else if (w_rx_first) begin
      r_inc_act  <= r_inc_pend && !r_dec_pend;
      r_dec_act  <= r_dec_pend && !r_inc_pend;
      r_inc_pend <= inc && !dec;
      r_dec_pend <= dec && !inc;
    end else begin
      if (inc && !dec) r_inc_pend <= 1'b1;
      if (dec && !inc) r_dec_pend <= 1'b1;
    end
  end

  always_comb begin
    w_rx_reg = sdh_region(32'(w_rx_row), 32'(w_rx_col), 32'(w_rx_sts));
    if (w_rx_row == RWID'(H3_ROW)) begin
      if (r_dec_act && (w_rx_col == CWID'(POH_COL - 1))) w_rx_reg = REG_VC4;
      if (r_inc_act && (w_rx_col == CWID'(POH_COL)))     w_rx_reg = REG_NONE;
    end
  end

  always_ff @(posedge clk19 or negedge rst) begin
    if (!rst) begin
      r_stmenrx  <= 1'b0;
      r_au4enrx  <= 1'b0;
      r_vc4enrx  <= 1'b0;
      r_tug3enrx <= 1'b0;
      r_rxdo     <= '0;
    end else begin
      r_stmenrx  <= w_rx_sync && (w_rx_reg == REG_STM);
      r_au4enrx  <= w_rx_sync && (w_rx_reg == REG_AU4);
      r_vc4enrx  <= w_rx_sync && (w_rx_reg == REG_VC4);
      r_tug3enrx <= w_rx_sync && (w_rx_reg == REG_TUG3);
      r_rxdo     <= dirx;
    end
  end

  always_ff @(posedge clk19 or negedge rst) begin
    if (!rst) begin
      r_state    <= HUNT;
      r_good     <= '0;
      r_bad      <= '0;
      r_bad_seen <= 1'b0;
      r_lof      <= 1'b1;
    end else begin
      case (r_state)
        HUNT: begin
          if (rxsof) begin
            r_state <= PRESYNC;
            r_good  <= GWID'(1);
          end
        end
        PRESYNC: begin
          if (w_rx_wrap && rxsof) begin
            r_good <= r_good + GWID'(1);
            if (r_good == GWID'(CONFIRM - 1)) begin
              r_state    <= SYNC;
              r_lof      <= 1'b0;
              r_bad      <= '0;
              r_bad_seen <= 1'b0;
            end
          end else if (w_rx_wrap || rxsof) begin
            r_state <= HUNT;
          end
        end
        SYNC: begin
          // A missing marker at the wrap opens a bad frame; a misplaced one only
          // counts if this frame has not already been marked bad.
          if (w_rx_wrap && rxsof) begin
            r_bad      <= '0;
            r_bad_seen <= 1'b0;
          end else if (w_rx_wrap || (rxsof && !r_bad_seen)) begin
            r_bad_seen <= 1'b1;
            r_bad      <= r_bad + BWID'(1);
            if (r_bad == BWID'(LOSSCNT - 1)) begin
              r_state <= HUNT;
              r_lof   <= 1'b1;
            end
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end

  assign stmenrx  = r_stmenrx;
  assign au4enrx  = r_au4enrx;
  assign vc4enrx  = r_vc4enrx;
  assign tug3enrx = r_tug3enrx;
  assign rxdo     = r_rxdo;
  assign rxlocked = w_rx_sync;
  assign lof      = r_lof;

endmodule

// File: tb/tb_sdh_frame_seq.sv
// Directed bench for sdh_frame_seq (NSTS=3): Tx sequencing, Rx lock/LOF, justification.
module tb_sdh_frame_seq;

  localparam int FRAME = 2430;

  logic       clk19 = 1'b0;
  logic       rst   = 1'b0;
  logic       rxsof = 1'b0;
  logic       inc   = 1'b0;
  logic       dec   = 1'b0;
  logic [7:0] dirx  = 8'h00;
  logic [7:0] stmdi = 8'hA5;
  logic [7:0] au4di = 8'h96;
  logic [7:0] vc4di = 8'h3C;
  logic [7:0] tug3di = 8'h7E;
  logic       stmentx, au4entx, vc4entx, tug3entx, txsof;
  logic       stmenrx, au4enrx, vc4enrx, tug3enrx, rxlocked, lof;
  logic [7:0] dotx, rxdo;
  logic [3:0] row;
  logic [6:0] col;
  logic [3:0] sts;
  logic [3:0] txen, rxen;
  logic [14:0] txpos;

  int n_vec  = 0;
  int n_err  = 0;
  int cyc    = 0;
  int rx_pos = 0;

  assign txen  = {stmentx, au4entx, vc4entx, tug3entx};
  assign rxen  = {stmenrx, au4enrx, vc4enrx, tug3enrx};
  assign txpos = {row, col, sts};

  always #5 clk19 = ~clk19;

  sdh_frame_seq #(
    .WID(8), .NSTS(3), .RWID(4), .CWID(7), .SWID(4), .CONFIRM(2), .LOSSCNT(4)
  ) dut (
    .clk19(clk19), .rst(rst), .rxsof(rxsof), .dirx(dirx), .inc(inc), .dec(dec),
    .stmentx(stmentx), .au4entx(au4entx), .vc4entx(vc4entx), .tug3entx(tug3entx),
    .stmdi(stmdi), .au4di(au4di), .vc4di(vc4di), .tug3di(tug3di),
    .dotx(dotx), .txsof(txsof), .row(row), .col(col), .sts(sts),
    .stmenrx(stmenrx), .au4enrx(au4enrx), .vc4enrx(vc4enrx), .tug3enrx(tug3enrx),
    .rxdo(rxdo), .rxlocked(rxlocked), .lof(lof)
  );

  task automatic tick();
    @(posedge clk19);
    #1;
    cyc++;
    rx_pos = (rx_pos + 1) % FRAME;
    dirx = 8'(cyc);
  endtask

  task automatic goto_pos(input int p);
    while (rx_pos != p) tick();
  endtask

  task automatic next_frame(input logic s);
    goto_pos(0);
    rxsof = s;
    tick();
    rxsof = 1'b0;
  endtask

  task automatic align_sof();
    rx_pos = 0;
    rxsof = 1'b1;
    tick();
    rxsof = 1'b0;
  endtask

  task automatic test_reset();
    $display("test_reset");
    repeat (3) @(posedge clk19);
    #1;
    if (dotx !== 8'h00) begin $display("FAIL rst_dotx: got %h want 00", dotx); n_err++; end n_vec++;
    if (txsof !== 1'b0) begin $display("FAIL rst_txsof: got %b want 0", txsof); n_err++; end n_vec++;
    if (lof !== 1'b1) begin $display("FAIL rst_lof: got %b want 1", lof); n_err++; end n_vec++;
    if (rxlocked !== 1'b0) begin $display("FAIL rst_locked: got %b want 0", rxlocked); n_err++; end n_vec++;
    if (rxen !== 4'b0000) begin $display("FAIL rst_rxen: got %b want 0000", rxen); n_err++; end n_vec++;
    if (txpos !== 15'd0) begin $display("FAIL rst_pos: got %h want 0", txpos); n_err++; end n_vec++;
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic test_tx();
    $display("test_tx");
    if (txen !== 4'b1000) begin $display("FAIL tx_first_en: got %b want 1000", txen); n_err++; end n_vec++;
    tick();
    if (dotx !== 8'hA5) begin $display("FAIL tx_first_byte: got %h want a5", dotx); n_err++; end n_vec++;
    if (txsof !== 1'b1) begin $display("FAIL tx_first_sof: got %b want 1", txsof); n_err++; end n_vec++;
    while (cyc < 9) tick();
    if (txen !== 4'b0010) begin $display("FAIL tx_vc4_en: got %b want 0010", txen); n_err++; end n_vec++;
    if (txpos !== {4'd0, 7'd3, 4'd0}) begin $display("FAIL tx_vc4_pos: got %h want %h", txpos, {4'd0, 7'd3, 4'd0}); n_err++; end n_vec++;
    tick();
    if (dotx !== 8'h3C) begin $display("FAIL tx_vc4_byte: got %h want 3c", dotx); n_err++; end n_vec++;
    if (txen !== 4'b0000) begin $display("FAIL tx_stuff_en: got %b want 0000", txen); n_err++; end n_vec++;
    tick();
    if (dotx !== 8'h00) begin $display("FAIL tx_stuff_byte: got %h want 00", dotx); n_err++; end n_vec++;
    tick();
    if (txen !== 4'b0001) begin $display("FAIL tx_tug3_en: got %b want 0001", txen); n_err++; end n_vec++;
    tick();
    if (dotx !== 8'h7E) begin $display("FAIL tx_tug3_byte: got %h want 7e", dotx); n_err++; end n_vec++;
    while (cyc < 810) tick();
    if (txen !== 4'b0100) begin $display("FAIL tx_au4_en: got %b want 0100", txen); n_err++; end n_vec++;
    if (txpos !== {4'd3, 7'd0, 4'd0}) begin $display("FAIL tx_au4_pos: got %h want %h", txpos, {4'd3, 7'd0, 4'd0}); n_err++; end n_vec++;
    tick();
    if (dotx !== 8'h96) begin $display("FAIL tx_au4_byte: got %h want 96", dotx); n_err++; end n_vec++;
    while (cyc < FRAME) tick();
    if (txsof !== 1'b0) begin $display("FAIL tx_sof_early: got %b want 0", txsof); n_err++; end n_vec++;
    tick();
    if (txsof !== 1'b1) begin $display("FAIL tx_sof_period: got %b want 1", txsof); n_err++; end n_vec++;
    if (dotx !== 8'hA5) begin $display("FAIL tx_wrap_byte: got %h want a5", dotx); n_err++; end n_vec++;
  endtask

  task automatic test_lock();
    $display("test_lock");
    align_sof();
    goto_pos(13);
    if (rxlocked !== 1'b0) begin $display("FAIL lock_presync: got %b want 0", rxlocked); n_err++; end n_vec++;
    if (rxen !== 4'b0000) begin $display("FAIL lock_presync_en: got %b want 0000", rxen); n_err++; end n_vec++;
    next_frame(1'b1);
    if (rxlocked !== 1'b1) begin $display("FAIL lock_sync: got %b want 1", rxlocked); n_err++; end n_vec++;
    if (lof !== 1'b0) begin $display("FAIL lock_lof: got %b want 0", lof); n_err++; end n_vec++;
    goto_pos(10);
    if (rxen !== 4'b0010) begin $display("FAIL lock_vc4: got %b want 0010", rxen); n_err++; end n_vec++;
    goto_pos(13);
    if (rxen !== 4'b0001) begin $display("FAIL lock_tug3: got %b want 0001", rxen); n_err++; end n_vec++;
    if (rxdo !== 8'(cyc - 1)) begin $display("FAIL lock_rxdo: got %h want %h", rxdo, 8'(cyc - 1)); n_err++; end n_vec++;
    goto_pos(811);
    if (rxen !== 4'b0100) begin $display("FAIL lock_au4: got %b want 0100", rxen); n_err++; end n_vec++;
    goto_pos(817);
    if (rxen !== 4'b0100) begin $display("FAIL lock_h3: got %b want 0100", rxen); n_err++; end n_vec++;
  endtask

  task automatic test_dec();
    $display("test_dec");
    goto_pos(1500);
    dec = 1'b1;
    tick();
    dec = 1'b0;
    next_frame(1'b1);
    for (int s = 0; s < 3; s++) begin
      goto_pos(817 + s);
      if (rxen !== 4'b0010) begin $display("FAIL dec_h3 sts%0d: got %b want 0010", s, rxen); n_err++; end n_vec++;
    end
    next_frame(1'b1);
    goto_pos(817);
    if (rxen !== 4'b0100) begin $display("FAIL dec_after: got %b want 0100", rxen); n_err++; end n_vec++;
  endtask

  task automatic test_inc_dec();
    $display("test_inc_dec");
    goto_pos(1500);
    inc = 1'b1;
    dec = 1'b1;
    tick();
    inc = 1'b0;
    dec = 1'b0;
    next_frame(1'b1);
    goto_pos(817);
    if (rxen !== 4'b0100) begin $display("FAIL incdec_h3: got %b want 0100", rxen); n_err++; end n_vec++;
    goto_pos(820);
    if (rxen !== 4'b0010) begin $display("FAIL incdec_poh: got %b want 0010", rxen); n_err++; end n_vec++;
  endtask

  task automatic test_inc();
    $display("test_inc");
    goto_pos(1500);
    inc = 1'b1;
    tick();
    inc = 1'b0;
    next_frame(1'b1);
    goto_pos(817);
    if (rxen !== 4'b0100) begin $display("FAIL inc_h3: got %b want 0100", rxen); n_err++; end n_vec++;
    for (int s = 0; s < 3; s++) begin
      goto_pos(820 + s);
      if (rxen !== 4'b0000) begin $display("FAIL inc_stuff sts%0d: got %b want 0000", s, rxen); n_err++; end n_vec++;
    end
    next_frame(1'b1);
    goto_pos(820);
    if (rxen !== 4'b0010) begin $display("FAIL inc_after: got %b want 0010", rxen); n_err++; end n_vec++;
  endtask

  task automatic test_lof();
    $display("test_lof");
    next_frame(1'b0);
    next_frame(1'b0);
    next_frame(1'b0);
    if (rxlocked !== 1'b1) begin $display("FAIL lof_hold3: got %b want 1", rxlocked); n_err++; end n_vec++;
    next_frame(1'b0);
    if (rxlocked !== 1'b0) begin $display("FAIL lof_unlock: got %b want 0", rxlocked); n_err++; end n_vec++;
    if (lof !== 1'b1) begin $display("FAIL lof_set: got %b want 1", lof); n_err++; end n_vec++;
    goto_pos(13);
    if (rxen !== 4'b0000) begin $display("FAIL lof_rxen: got %b want 0000", rxen); n_err++; end n_vec++;
    next_frame(1'b1);
    if (rxlocked !== 1'b0) begin $display("FAIL lof_relock1: got %b want 0", rxlocked); n_err++; end n_vec++;
    next_frame(1'b1);
    if (rxlocked !== 1'b1) begin $display("FAIL lof_relock2: got %b want 1", rxlocked); n_err++; end n_vec++;
    if (lof !== 1'b0) begin $display("FAIL lof_clear: got %b want 0", lof); n_err++; end n_vec++;
  endtask

  task automatic test_misplaced();
    $display("test_misplaced");
    goto_pos(100);
    rxsof = 1'b1;
    tick();
    rxsof = 1'b0;
    if (rxlocked !== 1'b1) begin $display("FAIL mis_sync_lock: got %b want 1", rxlocked); n_err++; end n_vec++;
    goto_pos(811);
    if (rxen !== 4'b0100) begin $display("FAIL mis_sync_noreload: got %b want 0100", rxen); n_err++; end n_vec++;
    next_frame(1'b0);
    next_frame(1'b0);
    if (rxlocked !== 1'b1) begin $display("FAIL mis_sync_bad3: got %b want 1", rxlocked); n_err++; end n_vec++;
    next_frame(1'b0);
    if (rxlocked !== 1'b0) begin $display("FAIL mis_sync_bad4: got %b want 0", rxlocked); n_err++; end n_vec++;
    next_frame(1'b1);
    goto_pos(100);
    rxsof = 1'b1;
    tick();
    rxsof = 1'b0;
    goto_pos(200);
    align_sof();
    next_frame(1'b1);
    if (rxlocked !== 1'b1) begin $display("FAIL mis_presync_relock: got %b want 1", rxlocked); n_err++; end n_vec++;
    goto_pos(811);
    if (rxen !== 4'b0100) begin $display("FAIL mis_presync_align: got %b want 0100", rxen); n_err++; end n_vec++;
  endtask

  task automatic test_async_reset();
    $display("test_async_reset");
    goto_pos(50);
    #3;
    rst = 1'b0;
    #1;
    if (lof !== 1'b1) begin $display("FAIL arst_lof: got %b want 1", lof); n_err++; end n_vec++;
    if (rxlocked !== 1'b0) begin $display("FAIL arst_locked: got %b want 0", rxlocked); n_err++; end n_vec++;
    if (rxdo !== 8'h00) begin $display("FAIL arst_rxdo: got %h want 00", rxdo); n_err++; end n_vec++;
    if (rxen !== 4'b0000) begin $display("FAIL arst_rxen: got %b want 0000", rxen); n_err++; end n_vec++;
    if (txpos !== 15'd0) begin $display("FAIL arst_pos: got %h want 0", txpos); n_err++; end n_vec++;
    if (dotx !== 8'h00) begin $display("FAIL arst_dotx: got %h want 00", dotx); n_err++; end n_vec++;
    @(posedge clk19);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_tx();
    test_lock();
    test_dec();
    test_inc_dec();
    test_inc();
    test_lof();
    test_misplaced();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
